// File: rtl/counter_updown_mod.sv
// WIDTH-bit up/down counter with programmable modulus, clamped parallel load,
// wrap or saturate at the boundaries, a registered terminal-count pulse and a sticky overflow flag.
module counter_updown_mod #(
    parameter int     WIDTH    = 8,
    parameter longint MODULO   = 256,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             zero
);

    // One extra bit keeps MODULO = 2^WIDTH representable without a special case.
    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] q_step;
    logic [WIDTH:0] d_clamp;
    logic           tc_step;

    always_comb begin
        q_ext   = {1'b0, q};
        q_step  = q_ext;
        tc_step = 1'b0;
        if (up) begin
            if (q_ext == MAX) begin
                tc_step = 1'b1;
                q_step  = SATURATE ? q_ext : '0;
            end else begin
                q_step = q_ext + ONE;
            end
        end else begin
            if (q_ext == '0) begin
                tc_step = 1'b1;
                q_step  = SATURATE ? q_ext : MAX;
            end else begin
                q_step = q_ext - ONE;
            end
        end
        d_clamp = ({1'b0, d} > MAX) ? MAX : {1'b0, d};
    end

    // Priority: reset > load > en; idle holds q and ovf but drops tc.
    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            q   <= d_clamp[WIDTH-1:0];
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (en) begin
            q   <= q_step[WIDTH-1:0];
            tc  <= tc_step;
            ovf <= ovf | tc_step;
        end else begin
            tc  <= 1'b0;
        end
    end

    assign zero = (q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: three configurations (256 wrap, 10 wrap,
// 10 saturate) share one stimulus bus; each sequence checks the instance it targets.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [7:0] d;

    logic [7:0] qa, qb, qc;
    logic       tca, tcb, tcc, ovfa, ovfb, ovfc, zeroa, zerob, zeroc;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(8), .MODULO(256), .SATURATE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(qa), .tc(tca), .ovf(ovfa), .zero(zeroa));

    counter_updown_mod #(.WIDTH(8), .MODULO(10), .SATURATE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(qb), .tc(tcb), .ovf(ovfb), .zero(zerob));

    counter_updown_mod #(.WIDTH(8), .MODULO(10), .SATURATE(1'b1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(qc), .tc(tcc), .ovf(ovfc), .zero(zeroc));

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] d;
        int         sel;
        logic [7:0] q;
        logic       tc;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic l, input logic e, input logic u,
                                input logic [7:0] dv, input int s, input logic [7:0] eq,
                                input logic etc, input logic eovf);
        vec_t v;
        v.rst = r; v.ld = l; v.en = e; v.up = u; v.d = dv;
        v.sel = s; v.q = eq; v.tc = etc; v.ovf = eovf;
        return v;
    endfunction

    task automatic drive(input logic r, input logic l, input logic e, input logic u,
                         input logic [7:0] dv);
        reset = r; load = l; en = e; up = u; d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int sel, input logic [7:0] eq, input logic etc,
                         input logic eovf, input string name);
        logic [7:0] aq;
        logic       atc, aovf, az, ez;
        case (sel)
            0:       begin aq = qa; atc = tca; aovf = ovfa; az = zeroa; end
            1:       begin aq = qb; atc = tcb; aovf = ovfb; az = zerob; end
            default: begin aq = qc; atc = tcc; aovf = ovfc; az = zeroc; end
        endcase
        ez = (eq == 8'd0);
        n_vec++;
        if (aq !== eq || atc !== etc || aovf !== eovf || az !== ez) begin
            n_bad++;
            $display("FAIL %s: got q=%0d tc=%0b ovf=%0b zero=%0b, want q=%0d tc=%0b ovf=%0b zero=%0b",
                     name, aq, atc, aovf, az, eq, etc, eovf, ez);
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = 8'd0;
        @(posedge clk);
        #1;

        // Modulo-10 down wrap from 3.
        tbl.push_back(mk(1, 0, 0, 0, 8'd0, 1, 8'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 1, 8'd3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd9, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd8, 0, 1));
        // Load clamp with en high clears ovf; reset beats load.
        tbl.push_back(mk(0, 1, 1, 1, 8'd15, 1, 8'd9, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 8'd5, 1, 8'd0, 0, 0));
        // Wrap to 9 sets ovf, count down to 5, then idle with up toggling.
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd9, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd8, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd7, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd6, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd5, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'd0, 1, 8'd5, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'd0, 1, 8'd5, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'd0, 1, 8'd5, 0, 1));
        // Direction flips take effect immediately.
        tbl.push_back(mk(0, 0, 1, 1, 8'd0, 1, 8'd6, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0, 1, 8'd5, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 8'd0, 1, 8'd6, 0, 1));
        // Saturate instance: climb from 8 and hold at 9.
        tbl.push_back(mk(1, 0, 0, 0, 8'd0, 2, 8'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'd8, 2, 8'd8, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'd0, 2, 8'd9, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'd0, 2, 8'd9, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 8'd0, 2, 8'd9, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 8'd0, 2, 8'd9, 1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].d);
            check(tbl[i].sel, tbl[i].q, tbl[i].tc, tbl[i].ovf, $sformatf("vec%0d", i));
        end

        // Saturate instance: down from 9 to 0, then hold at 0 with tc pulsing.
        for (int k = 8; k >= 0; k--) begin
            drive(0, 0, 1, 0, 8'd0);
            check(2, 8'(k), 1'b0, 1'b1, "sat_down");
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 0, 8'd0);
            check(2, 8'd0, 1'b1, 1'b1, "sat_hold0");
        end

        // Full 8-bit up-count with wrap.
        drive(1, 0, 0, 0, 8'd0);
        check(0, 8'd0, 1'b0, 1'b0, "a_reset");
        for (int k = 1; k < 256; k++) begin
            drive(0, 0, 1, 1, 8'd0);
            check(0, 8'(k), 1'b0, 1'b0, "a_up");
        end
        drive(0, 0, 1, 1, 8'd0);
        check(0, 8'd0, 1'b1, 1'b1, "a_wrap");
        for (int k = 1; k <= 8'h7e; k++) begin
            drive(0, 0, 1, 1, 8'd0);
            check(0, 8'(k), 1'b0, 1'b1, "a_up2");
        end

        // Reset while counting: no partial step, ovf cleared, resume from 1.
        drive(1, 0, 1, 1, 8'd0);
        check(0, 8'd0, 1'b0, 1'b0, "a_mid_reset");
        drive(0, 0, 1, 1, 8'd0);
        check(0, 8'd1, 1'b0, 1'b0, "a_resume");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
